// File: rtl/motion_scheduler.sv
// Motion request arbiter: avoidance beats manual beats tracking; sequences timed avoid manoeuvres.
// Optional MOTION_MAN_PREEMPT_EN lets a manual command abort an in-progress manoeuvre.
module motion_scheduler #(
  parameter int unsigned STOP_TICKS = 4,
  parameter int unsigned TURN_TICKS = 50,
  parameter int unsigned BACK_TICKS = 80
) (
  input  logic       clk,
  input  logic       CR,
  input  logic       tick,
  input  logic       en,
  input  logic [1:0] avoid_sig,
  input  logic       man_valid,
  input  logic [2:0] man_cmd,
  input  logic       trk_en,
  input  logic [2:0] trk_cmd,
  output logic [2:0] cmd,
  output logic [1:0] src,
  output logic       busy
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RUN    = 3'd1;
  localparam logic [2:0] S_DWELL  = 3'd2;
  localparam logic [2:0] S_TURN_L = 3'd3;
  localparam logic [2:0] S_TURN_R = 3'd4;
  localparam logic [2:0] S_BACK   = 3'd5;

  localparam logic [2:0] CMD_STOP  = 3'b000;
  localparam logic [2:0] CMD_LEFT  = 3'b010;
  localparam logic [2:0] CMD_RIGHT = 3'b011;
  localparam logic [2:0] CMD_BACK  = 3'b100;

  localparam logic [1:0] SRC_NONE  = 2'b00;
  localparam logic [1:0] SRC_TRK   = 2'b01;
  localparam logic [1:0] SRC_MAN   = 2'b10;
  localparam logic [1:0] SRC_AVOID = 2'b11;

  logic [2:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] target_q, target_d;
  logic [2:0] cmd_q, cmd_d;
  logic [1:0] src_q, src_d;
  logic       busy_q, busy_d;

  logic [2:0] sel_cmd;
  logic [1:0] sel_src;
  logic       done;
  logic       preempt;

  assign done = tick && (cnt_q == 8'd1);

`ifdef MOTION_MAN_PREEMPT_EN
  assign preempt = man_valid;
`else
  assign preempt = 1'b0;
`endif

  always_comb begin
    sel_cmd = CMD_STOP;
    sel_src = SRC_NONE;
    if (man_valid) begin
      sel_cmd = man_cmd;
      sel_src = SRC_MAN;
    end else if (trk_en) begin
      sel_cmd = trk_cmd;
      sel_src = SRC_TRK;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    cmd_d    = cmd_q;
    src_d    = src_q;
    busy_d   = busy_q;
    if (!en) begin
      state_d = S_IDLE;
      cnt_d   = 8'd0;
      cmd_d   = CMD_STOP;
      src_d   = SRC_NONE;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_RUN;
          cmd_d   = CMD_STOP;
          src_d   = SRC_NONE;
          busy_d  = 1'b0;
        end
        S_RUN: begin
          if (avoid_sig != 2'b00) begin
            state_d  = S_DWELL;
            cnt_d    = 8'(STOP_TICKS);
            target_d = (avoid_sig == 2'b10) ? S_TURN_L :
                       (avoid_sig == 2'b01) ? S_TURN_R : S_BACK;
            cmd_d    = CMD_STOP;
            src_d    = SRC_AVOID;
            busy_d   = 1'b1;
          end else begin
            cmd_d  = sel_cmd;
            src_d  = sel_src;
            busy_d = 1'b0;
          end
        end
        S_DWELL, S_TURN_L, S_TURN_R, S_BACK: begin
          if (preempt) begin
            state_d = S_RUN;
            cnt_d   = 8'd0;
            cmd_d   = man_cmd;
            src_d   = SRC_MAN;
            busy_d  = 1'b0;
          end else if (done) begin
            // Completion reloads the counter, so a coincident tick never counts twice.
            if (state_q == S_DWELL) begin
              state_d = target_q;
              cnt_d   = (target_q == S_BACK) ? 8'(BACK_TICKS) : 8'(TURN_TICKS);
              cmd_d   = (target_q == S_TURN_L) ? CMD_LEFT :
                        (target_q == S_TURN_R) ? CMD_RIGHT : CMD_BACK;
            end else if (state_q == S_BACK) begin
              state_d  = S_DWELL;
              cnt_d    = 8'(STOP_TICKS);
              target_d = S_TURN_R;
              cmd_d    = CMD_STOP;
            end else begin
              state_d = S_RUN;
              cnt_d   = 8'd0;
              cmd_d   = sel_cmd;
              src_d   = sel_src;
              busy_d  = 1'b0;
            end
          end else if (tick) begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = 8'd0;
          cmd_d   = CMD_STOP;
          src_d   = SRC_NONE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge CR) begin
    if (CR) begin
      state_q  <= S_IDLE;
      cnt_q    <= 8'd0;
      target_q <= S_TURN_R;
      cmd_q    <= CMD_STOP;
      src_q    <= SRC_NONE;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      cmd_q    <= cmd_d;
      src_q    <= src_d;
      busy_q   <= busy_d;
    end
  end

  assign cmd  = cmd_q;
  assign src  = src_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_motion_scheduler.sv
// Bench for motion_scheduler: directed scenarios then random traffic, checked each clk
// against a phase-queue reference model (honours MOTION_MAN_PREEMPT_EN).
module tb_motion_scheduler;

  localparam int unsigned STOP_T = 2;
  localparam int unsigned TURN_T = 3;
  localparam int unsigned BACK_T = 4;

  logic       clk = 1'b0;
  logic       CR;
  logic       tick;
  logic       en;
  logic [1:0] avoid_sig;
  logic       man_valid;
  logic [2:0] man_cmd;
  logic       trk_en;
  logic [2:0] trk_cmd;
  logic [2:0] cmd;
  logic [1:0] src;
  logic       busy;

  motion_scheduler #(
    .STOP_TICKS(STOP_T),
    .TURN_TICKS(TURN_T),
    .BACK_TICKS(BACK_T)
  ) dut (
    .clk      (clk),
    .CR       (CR),
    .tick     (tick),
    .en       (en),
    .avoid_sig(avoid_sig),
    .man_valid(man_valid),
    .man_cmd  (man_cmd),
    .trk_en   (trk_en),
    .trk_cmd  (trk_cmd),
    .cmd      (cmd),
    .src      (src),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int ncomp = 0;
  int nfail = 0;
  int tph   = 0;

  // Reference model: a manoeuvre is a queue of (command, ticks remaining) phases.
  bit         m_idle;
  logic [2:0] pc_q[$];
  int         pr_q[$];
  logic [2:0] e_cmd;
  logic [1:0] e_src;
  logic       e_busy;

  task automatic model_reset();
    m_idle = 1'b1;
    pc_q.delete();
    pr_q.delete();
    e_cmd  = 3'b000;
    e_src  = 2'b00;
    e_busy = 1'b0;
  endtask

  task automatic model_select();
    e_busy = 1'b0;
    if (man_valid) begin
      e_cmd = man_cmd; e_src = 2'b10;
    end else if (trk_en) begin
      e_cmd = trk_cmd; e_src = 2'b01;
    end else begin
      e_cmd = 3'b000; e_src = 2'b00;
    end
  endtask

  task automatic push_phase(input logic [2:0] c, input int n);
    pc_q.push_back(c);
    pr_q.push_back(n);
  endtask

  task automatic model_step();
    bit pre;
`ifdef MOTION_MAN_PREEMPT_EN
    pre = man_valid;
`else
    pre = 1'b0;
`endif
    if (CR || !en) begin
      model_reset();
    end else if (m_idle) begin
      m_idle = 1'b0;
      e_cmd = 3'b000; e_src = 2'b00; e_busy = 1'b0;
    end else if (pc_q.size() != 0) begin
      if (pre) begin
        pc_q.delete();
        pr_q.delete();
        e_cmd = man_cmd; e_src = 2'b10; e_busy = 1'b0;
      end else begin
        if (tick) begin
          pr_q[0] = pr_q[0] - 1;
          if (pr_q[0] == 0) begin
            void'(pc_q.pop_front());
            void'(pr_q.pop_front());
          end
        end
        if (pc_q.size() == 0) model_select();
        else begin
          e_cmd = pc_q[0]; e_src = 2'b11; e_busy = 1'b1;
        end
      end
    end else if (avoid_sig != 2'b00) begin
      push_phase(3'b000, STOP_T);
      case (avoid_sig)
        2'b10: push_phase(3'b010, TURN_T);
        2'b01: push_phase(3'b011, TURN_T);
        default: begin
          push_phase(3'b100, BACK_T);
          push_phase(3'b000, STOP_T);
          push_phase(3'b011, TURN_T);
        end
      endcase
      e_cmd = 3'b000; e_src = 2'b11; e_busy = 1'b1;
    end else begin
      model_select();
    end
  endtask

  task automatic check_now(input string tag);
    ncomp++;
    assert (cmd === e_cmd) else begin
      nfail++;
      $error("FAIL %s cmd: got %b want %b", tag, cmd, e_cmd);
    end
    ncomp++;
    assert (src === e_src) else begin
      nfail++;
      $error("FAIL %s src: got %b want %b", tag, src, e_src);
    end
    ncomp++;
    assert (busy === e_busy) else begin
      nfail++;
      $error("FAIL %s busy: got %b want %b", tag, busy, e_busy);
    end
  endtask

  task automatic expect_out(input string tag, input logic [2:0] c, input logic [1:0] s,
                            input logic b);
    ncomp++;
    assert ({cmd, src, busy} === {c, s, b}) else begin
      nfail++;
      $error("FAIL %s: got cmd=%b src=%b busy=%b want cmd=%b src=%b busy=%b",
             tag, cmd, src, busy, c, s, b);
    end
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_now(tag);
  endtask

  // Tick strobe once every 4 clk.
  task automatic tcycle(input string tag);
    tick = (tph == 3);
    tph  = (tph + 1) % 4;
    cycle(tag);
  endtask

  task automatic timeout(input string tag);
    ncomp++;
    nfail++;
    $error("FAIL %s timeout: got no event want event within bound", tag);
  endtask

  task automatic wait_done(input string tag);
    int k;
    for (k = 0; k < 300 && pc_q.size() != 0; k++) tcycle(tag);
    if (pc_q.size() != 0) timeout(tag);
  endtask

  task automatic wait_head(input string tag, input logic [2:0] c, input int n);
    int k;
    for (k = 0; k < 300 && !(pc_q.size() == n && pc_q[0] == c); k++) tcycle(tag);
    if (!(pc_q.size() == n && pc_q[0] == c)) timeout(tag);
  endtask

  initial begin
    CR = 1'b1; tick = 1'b0; en = 1'b0; avoid_sig = 2'b00;
    man_valid = 1'b0; man_cmd = 3'b000; trk_en = 1'b0; trk_cmd = 3'b000;
    model_reset();
    #2;
    check_now("reset");
    cycle("reset_hold");

    // Priority in RUN
    CR = 1'b0; en = 1'b1; trk_en = 1'b1; trk_cmd = 3'b001;
    tcycle("release");
    tcycle("track");
    expect_out("track_sel", 3'b001, 2'b01, 1'b0);
    man_valid = 1'b1; man_cmd = 3'b010;
    tcycle("manual");
    expect_out("manual_sel", 3'b010, 2'b10, 1'b0);
    man_valid = 1'b0;

    // Turn left
    avoid_sig = 2'b10;
    tcycle("left_start");
    expect_out("left_dwell", 3'b000, 2'b11, 1'b1);
    avoid_sig = 2'b00;
    wait_head("left_turn", 3'b010, 1);
    expect_out("left_cmd", 3'b010, 2'b11, 1'b1);
    wait_done("left_run");

    // Reverse, with avoid toggled mid-BACK
    avoid_sig = 2'b11;
    tcycle("rev_start");
    avoid_sig = 2'b00;
    wait_head("rev_back", 3'b100, 3);
    tcycle("rev_back2");
    avoid_sig = 2'b10;
    for (int i = 0; i < 6; i++) tcycle("rev_toggle");
    expect_out("rev_ignore", 3'b100, 2'b11, 1'b1);
    avoid_sig = 2'b00;
    wait_done("rev_run");

    // Enable drop on the completing tick of TURN_R
    avoid_sig = 2'b01;
    tcycle("drop_start");
    avoid_sig = 2'b00;
    begin
      bit hit = 1'b0;
      for (int k = 0; k < 300 && !hit; k++) begin
        if (pc_q.size() == 1 && pc_q[0] == 3'b011 && pr_q[0] == 1) begin
          tick = 1'b1; en = 1'b0;
          cycle("drop_edge");
          expect_out("drop_idle", 3'b000, 2'b00, 1'b0);
          hit = 1'b1;
        end else tcycle("drop_wait");
      end
      if (!hit) timeout("drop_wait");
    end
    tcycle("drop_stay");
    expect_out("drop_no_run", 3'b000, 2'b00, 1'b0);
    en = 1'b1;
    tcycle("reenable");
    tcycle("reenable2");

    // Manual command during TURN_L
    trk_en = 1'b0;
    avoid_sig = 2'b10;
    tcycle("pre_start");
    avoid_sig = 2'b00;
    wait_head("pre_left", 3'b010, 1);
    tcycle("pre_left2");
    man_valid = 1'b1; man_cmd = 3'b001;
    tcycle("pre_req");
`ifdef MOTION_MAN_PREEMPT_EN
    expect_out("pre_abort", 3'b001, 2'b10, 1'b0);
`else
    expect_out("pre_ignored", 3'b010, 2'b11, 1'b1);
`endif
    wait_done("pre_done");
    expect_out("pre_after", 3'b001, 2'b10, 1'b0);
    man_valid = 1'b0;

    // Async reset mid-BACK
    avoid_sig = 2'b11;
    tcycle("rst_start");
    avoid_sig = 2'b00;
    wait_head("rst_back", 3'b100, 3);
    tcycle("rst_back2");
    @(negedge clk);
    CR = 1'b1;
    #1;
    model_reset();
    expect_out("async_rst", 3'b000, 2'b00, 1'b0);
    cycle("rst_hold");
    CR = 1'b0; trk_en = 1'b1; trk_cmd = 3'b111;
    tcycle("rst_release");
    tcycle("rst_run");
    expect_out("rsvd_pass", 3'b111, 2'b01, 1'b0);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      tick      = ($urandom_range(0, 3) == 0);
      en        = ($urandom_range(0, 40) != 0);
      avoid_sig = ($urandom_range(0, 11) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      man_valid = ($urandom_range(0, 9) == 0);
      man_cmd   = 3'($urandom);
      trk_en    = $urandom_range(0, 1) == 1;
      trk_cmd   = 3'($urandom);
      CR        = ($urandom_range(0, 499) == 0);
      cycle("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
